mc_ctrl: RTL

Multi-cycle control sequencer for the MIPS datapath. It replaces the per-instruction combinational decode with a state machine, so one instruction takes 2–5 cycles and the single ALU, register file and memory port are reused across states. It sits beside the datapath and drives the PC/IR write enables, the register-file and memory write strobes, and the ALU, NPC and write-back mux selects. It decodes Op and Funct from the instruction register.

---
 rtl/mc_ctrl.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB state machine driving datapath enables and mux selects.
// Optional build macro MC_HALT_EN adds a halt input that parks the sequencer in FETCH.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
`ifdef MC_HALT_EN
  input  logic       halt,
`endif
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       EXTOp,
  output logic       ALUSrc,
  output logic [4:0] ALUOp,
  output logic [3:0] NPCOp,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_JR = 6'h08, F_ADDU = 6'h21, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

  localparam logic [4:0] ALU_NOP = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR = 5'd4, ALU_SLT = 5'd5, ALU_SLL = 5'd6;
  localparam logic [3:0] NPC_PC4 = 4'd0, NPC_BRANCH = 4'd1, NPC_JUMP = 4'd2, NPC_JR = 4'd3;

  state_t     state_reg, state_next;
  logic       fetch_hold;
  logic       is_legal;
  logic [4:0] alu_op_dec;
  logic       alu_src_dec;
  logic       ext_op_dec;

`ifdef MC_HALT_EN
  assign fetch_hold = halt;
`else
  assign fetch_hold = 1'b0;
`endif

  assign state = state_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  // ALU controls depend only on the instruction; EXEC, MEM and WB all present them.
  always_comb begin
    alu_op_dec  = ALU_NOP;
    alu_src_dec = 1'b0;
    ext_op_dec  = 1'b0;
    is_legal    = 1'b1;
    case (Op)
      OP_RTYPE: begin
        case (Funct)
          F_ADDU:  alu_op_dec = ALU_ADD;
          F_SUBU:  alu_op_dec = ALU_SUB;
          F_AND:   alu_op_dec = ALU_AND;
          F_OR:    alu_op_dec = ALU_OR;
          F_SLT:   alu_op_dec = ALU_SLT;
          F_SLL:   alu_op_dec = ALU_SLL;
          F_JR:    alu_op_dec = ALU_NOP;
          default: is_legal   = 1'b0;
        endcase
      end
      OP_J, OP_JAL: alu_op_dec = ALU_NOP;
      OP_BEQ:       alu_op_dec = ALU_SUB;
      OP_ORI: begin
        alu_op_dec  = ALU_OR;
        alu_src_dec = 1'b1;
      end
      OP_ADDI, OP_LW, OP_SW: begin
        alu_op_dec  = ALU_ADD;
        alu_src_dec = 1'b1;
        ext_op_dec  = 1'b1;
      end
      default: is_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_NOP;
    NPCOp    = NPC_PC4;
    GPRSel   = 2'd0;
    WDSel    = 2'd0;
    illegal  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (!fetch_hold) begin
          IRWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = S_FETCH;
        if (!is_legal) begin
          // Undecoded instructions retire as a NOP so the program keeps moving.
          illegal = 1'b1;
          PCWrite = 1'b1;
        end else if (Op == OP_J) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_JUMP;
        end else if (Op == OP_JAL) begin
          PCWrite  = 1'b1;
          NPCOp    = NPC_JUMP;
          RegWrite = 1'b1;
          GPRSel   = 2'd2;
          WDSel    = 2'd2;
        end else if (Op == OP_RTYPE && Funct == F_JR) begin
          PCWrite = 1'b1;
          NPCOp   = NPC_JR;
        end else begin
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        ALUOp  = alu_op_dec;
        ALUSrc = alu_src_dec;
        EXTOp  = ext_op_dec;
        if (Op == OP_BEQ) begin
          PCWrite    = 1'b1;
          NPCOp      = Zero ? NPC_BRANCH : NPC_PC4;
          state_next = S_FETCH;
        end else if (Op == OP_LW || Op == OP_SW) begin
          state_next = S_MEM;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        ALUOp  = alu_op_dec;
        ALUSrc = alu_src_dec;
        EXTOp  = ext_op_dec;
        if (Op == OP_SW) begin
          MemWrite   = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WB;
        end
      end
      S_WB: begin
        ALUOp      = alu_op_dec;
        ALUSrc     = alu_src_dec;
        EXTOp      = ext_op_dec;
        RegWrite   = 1'b1;
        PCWrite    = 1'b1;
        GPRSel     = (Op == OP_RTYPE) ? 2'd0 : 2'd1;
        WDSel      = (Op == OP_LW) ? 2'd1 : 2'd0;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
    // Reset aborts the instruction in flight: no write of any kind in that cycle.
    if (rst) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      EXTOp    = 1'b0;
      ALUSrc   = 1'b0;
      ALUOp    = ALU_NOP;
      NPCOp    = NPC_PC4;
      GPRSel   = 2'd0;
      WDSel    = 2'd0;
      illegal  = 1'b0;
    end
  end

endmodule
